// File: rtl/tia_scan_doubler.sv
// Line-doubling scan converter: captures 160-pixel TIA lines into a ping-pong
// buffer and replays each line twice at VGA rate with 4x horizontal repeat.
module tia_scan_doubler #(
    parameter int H_TOTAL      = 800,
    parameter int H_ACTIVE     = 640,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_LEN   = 96,
    parameter int PIX_W        = 160,
    parameter int REP          = 4,
    parameter int TIA_HSTART   = 68
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tiaPixEn,
    input  logic       tiaHsync,
    input  logic       tiaVsync,
    input  logic       tiaBlank,
    input  logic [3:0] tiaLum,
    input  logic [3:0] tiaHue,
    output logic [3:0] outLum,
    output logic [3:0] outHue,
    output logic       vgaHsync,
    output logic       vgaVsync,
    output logic       vgaBlank
);

    localparam int HW  = $clog2(H_TOTAL);
    localparam int AW  = $clog2(PIX_W);
    localparam int RSH = $clog2(REP);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_LO  = HW'(H_SYNC_START);
    localparam logic [HW-1:0] HS_HI  = HW'(H_SYNC_START + H_SYNC_LEN);
    localparam logic [7:0]    WR_LO  = 8'(TIA_HSTART);
    localparam logic [7:0]    WR_HI  = 8'(TIA_HSTART + PIX_W);
    localparam logic [AW:0]   BANK_OFS  = (AW + 1)'(PIX_W);
    localparam logic [AW:0]   BANK_ZERO = {(AW + 1){1'b0}};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LINE0 = 2'd1;
    localparam logic [1:0] ST_LINE1 = 2'd2;

    logic          tia_hsync_r;
    logic          line_evt_s;
    logic [7:0]    ccx_r;
    logic [7:0]    ccx_eff_s;
    logic [7:0]    ccx_nxt_s;
    logic [AW-1:0] wr_off_s;
    logic          wr_bank_r;
    logic          wr_bank_eff_s;
    logic          rd_bank_r;
    logic          wr_valid_r;
    logic          line_valid_r;
    logic          v_latch_r;
    logic          wr_en_s;
    logic [AW:0]   wr_idx_s;
    logic [7:0]    wr_data_s;
    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic [HW-1:0] hcount_r;
    logic [HW-1:0] hcount_nxt_s;
    logic [AW-1:0] rd_pix_s;
    logic [AW:0]   rd_idx_s;
    logic          active_s;
    logic          hsync_term_s;
    logic [7:0]    mem [0:2*PIX_W-1];
    logic [7:0]    ram_q_r;
    logic          act_p1_r;
    logic          vld_p1_r;
    logic          hs_p1_r;
    logic          vs_p1_r;
    logic          act_p2_r;
    logic          hs_p2_r;
    logic          vs_p2_r;

    assign line_evt_s = tiaHsync & ~tia_hsync_r;

    // Capture side: a strobe coincident with the line event belongs to the new line.
    always_comb begin
        ccx_eff_s     = line_evt_s ? 8'd0 : ccx_r;
        wr_bank_eff_s = line_evt_s ? ~wr_bank_r : wr_bank_r;
        wr_off_s      = AW'(ccx_eff_s - WR_LO);
        wr_en_s       = tiaPixEn && (ccx_eff_s >= WR_LO) && (ccx_eff_s < WR_HI);
        wr_data_s     = tiaBlank ? 8'h00 : {tiaHue, tiaLum};
        wr_idx_s      = {1'b0, wr_off_s} + (wr_bank_eff_s ? BANK_OFS : BANK_ZERO);
        if (!tiaPixEn) begin
            ccx_nxt_s = ccx_eff_s;
        end else if (ccx_eff_s == 8'hFF) begin
            ccx_nxt_s = 8'hFF;
        end else begin
            ccx_nxt_s = ccx_eff_s + 8'd1;
        end
    end

    // Replay sequencer: each captured line is played as LINE0 then LINE1.
    always_comb begin
        state_nxt_s  = state_r;
        hcount_nxt_s = hcount_r;
        if (line_evt_s) begin
            state_nxt_s  = ST_LINE0;
            hcount_nxt_s = {HW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    hcount_nxt_s = {HW{1'b0}};
                end
                ST_LINE0: begin
                    if (hcount_r == H_LAST) begin
                        hcount_nxt_s = {HW{1'b0}};
                        state_nxt_s  = ST_LINE1;
                    end else begin
                        hcount_nxt_s = hcount_r + {{(HW-1){1'b0}}, 1'b1};
                    end
                end
                ST_LINE1: begin
                    if (hcount_r == H_LAST) begin
                        hcount_nxt_s = {HW{1'b0}};
                        state_nxt_s  = ST_IDLE;
                    end else begin
                        hcount_nxt_s = hcount_r + {{(HW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_nxt_s  = ST_IDLE;
                    hcount_nxt_s = {HW{1'b0}};
                end
            endcase
        end
    end

    // Read address and per-clock video/sync terms derived from the sequencer.
    always_comb begin
        rd_pix_s     = AW'(hcount_r >> RSH);
        rd_idx_s     = {1'b0, rd_pix_s} + (rd_bank_r ? BANK_OFS : BANK_ZERO);
        active_s     = (state_r != ST_IDLE) && (hcount_r < H_ACT);
        hsync_term_s = (state_r != ST_IDLE) && (hcount_r >= HS_LO) && (hcount_r < HS_HI);
    end

    // Control state: line-event bookkeeping, bank swap, counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tia_hsync_r  <= 1'b0;
            ccx_r        <= 8'd0;
            wr_bank_r    <= 1'b0;
            rd_bank_r    <= 1'b0;
            wr_valid_r   <= 1'b0;
            line_valid_r <= 1'b0;
            v_latch_r    <= 1'b0;
            state_r      <= ST_IDLE;
            hcount_r     <= {HW{1'b0}};
        end else begin
            tia_hsync_r <= tiaHsync;
            ccx_r       <= ccx_nxt_s;
            state_r     <= state_nxt_s;
            hcount_r    <= hcount_nxt_s;
            if (line_evt_s) begin
                rd_bank_r    <= wr_bank_r;
                wr_bank_r    <= ~wr_bank_r;
                v_latch_r    <= tiaVsync;
                line_valid_r <= wr_valid_r;
                wr_valid_r   <= 1'b1;
            end
        end
    end

    // Line buffer: contents deliberately not reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[wr_idx_s] <= wr_data_s;
        end
        ram_q_r <= mem[rd_idx_s];
    end

    // Output pipeline: terms ride alongside the RAM read, sync lags index by one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_p1_r <= 1'b0;
            vld_p1_r <= 1'b0;
            hs_p1_r  <= 1'b0;
            vs_p1_r  <= 1'b0;
            act_p2_r <= 1'b0;
            hs_p2_r  <= 1'b0;
            vs_p2_r  <= 1'b0;
            outLum   <= 4'd0;
            outHue   <= 4'd0;
            vgaHsync <= 1'b0;
            vgaVsync <= 1'b0;
            vgaBlank <= 1'b1;
        end else begin
            act_p1_r <= active_s;
            vld_p1_r <= line_valid_r;
            hs_p1_r  <= hsync_term_s;
            vs_p1_r  <= v_latch_r;
            if (act_p1_r && vld_p1_r) begin
                outHue <= ram_q_r[7:4];
                outLum <= ram_q_r[3:0];
            end else begin
                outHue <= 4'd0;
                outLum <= 4'd0;
            end
            act_p2_r <= act_p1_r;
            hs_p2_r  <= hs_p1_r;
            vs_p2_r  <= vs_p1_r;
            vgaHsync <= hs_p2_r;
            vgaVsync <= vs_p2_r;
            vgaBlank <= ~act_p2_r;
        end
    end

endmodule

// File: tb/tb_tia_scan_doubler.sv
// Bench for tia_scan_doubler: line-level reference model checked every clock,
// plus a table of hand-derived probe points on one replayed line.
module tb_tia_scan_doubler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tiaPixEn, tiaHsync, tiaVsync, tiaBlank;
    logic [3:0] tiaLum, tiaHue;
    logic [3:0] outLum, outHue;
    logic       vgaHsync, vgaVsync, vgaBlank;

    always #5 clk = ~clk;

    tia_scan_doubler dut (
        .clk(clk), .reset_n(reset_n),
        .tiaPixEn(tiaPixEn), .tiaHsync(tiaHsync), .tiaVsync(tiaVsync),
        .tiaBlank(tiaBlank), .tiaLum(tiaLum), .tiaHue(tiaHue),
        .outLum(outLum), .outHue(outHue),
        .vgaHsync(vgaHsync), .vgaVsync(vgaVsync), .vgaBlank(vgaBlank)
    );

    typedef struct {
        int         t;
        logic [3:0] hue;
        logic [3:0] lum;
        logic       blank;
        logic       hs;
        logic       vs;
    } probe_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Line-level model: what each replayed line should show.
    logic [7:0] cap_cur [160];
    logic [7:0] cap_prev[160];
    logic [7:0] pend_cap[160];
    logic [3:0] tx_lum[160];
    logic [3:0] tx_hue[160];
    bit         tx_blk[160];
    bit  valid_cur, valid_prev, vl_cur, vl_prev, idle_cur, idle_prev;
    int  len_cur, len_prev, ev_count;
    logic [10:0] trace[1600];

    task automatic check(input string nm, input int t, input logic [10:0] got, input logic [10:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got{lum,hue,blank,hs,vs}=%03h expected=%03h", nm, t, got, exp);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
        end
    endtask

    // Position h clocks after the latest line event (negative = previous line).
    function automatic void line_pt(input int h, output bit act, output logic [7:0] val,
                                    output bit hs, output bit vl);
        bit idle, use_cur;
        int hh, hc;
        act = 1'b0; val = 8'h00; hs = 1'b0;
        if (h >= 0) begin
            idle = idle_cur; vl = vl_cur; hh = h; use_cur = 1'b1;
        end else begin
            idle = idle_prev; vl = vl_prev; hh = h + len_prev; use_cur = 1'b0;
        end
        if (!idle && hh >= 0 && hh < 1600) begin
            hc  = hh % 800;
            act = (hc < 640);
            hs  = (hc >= 656 && hc < 752);
            if (act) begin
                if (use_cur) val = valid_cur ? cap_cur[hc/4] : 8'h00;
                else         val = valid_prev ? cap_prev[hc/4] : 8'h00;
            end
        end
    endfunction

    // Index appears two clocks after hCount, sync/blank three.
    function automatic logic [10:0] expect_at(input int t);
        bit a, hs, vl, a2, hs2, vl2;
        logic [7:0] v, v2;
        line_pt(t - 2, a, v, hs, vl);
        line_pt(t - 3, a2, v2, hs2, vl2);
        return {v[3:0], v[7:4], ~a2, hs2, vl2};
    endfunction

    task automatic model_reset();
        idle_cur = 1'b1; vl_cur = 1'b0; valid_cur = 1'b0; ev_count = 0; len_cur = 0;
    endtask

    task automatic set_line(input int k, input int nblank);
        for (int p = 0; p < 160; p++) begin
            tx_hue[p] = p[3:0];
            tx_lum[p] = k[3:0];
            tx_blk[p] = (p < nblank);
        end
    endtask

    task automatic rand_line();
        for (int p = 0; p < 160; p++) begin
            tx_hue[p] = 4'($urandom_range(15));
            tx_lum[p] = 4'($urandom_range(15));
            tx_blk[p] = ($urandom_range(7) == 0);
        end
    endtask

    // One TIA line: event at c=0, strobes every per clocks from phase ph.
    task automatic run_line(input int len, input int per, input int ph, input bit vs, input bit rec);
        int j;
        logic [10:0] got;
        len_prev = len_cur; idle_prev = idle_cur; valid_prev = valid_cur; vl_prev = vl_cur;
        cap_prev = cap_cur;
        cap_cur  = pend_cap;
        ev_count++;
        valid_cur = (ev_count >= 2);
        vl_cur = vs; len_cur = len; idle_cur = 1'b0;
        for (int c = 0; c < len; c++) begin
            tiaHsync = (c < 8);
            tiaVsync = vs;
            j = -1;
            if (c >= ph && (c - ph) % per == 0 && (c - ph) / per < 228) j = (c - ph) / per;
            tiaPixEn = (j >= 0);
            if (j >= 68 && j < 228) begin
                tiaLum = tx_lum[j-68]; tiaHue = tx_hue[j-68]; tiaBlank = tx_blk[j-68];
            end else begin
                tiaLum = 4'($urandom_range(15)); tiaHue = 4'($urandom_range(15));
                tiaBlank = 1'($urandom_range(1));
            end
            @(posedge clk); #1;
            got = {outLum, outHue, vgaBlank, vgaHsync, vgaVsync};
            if (rec) trace[c] = got;
            check("cycle", c, got, expect_at(c));
        end
        for (int p = 0; p < 160; p++)
            pend_cap[p] = tx_blk[p] ? 8'h00 : {tx_hue[p], tx_lum[p]};
    endtask

    task automatic idle_cycles(input int n);
        tiaHsync = 1'b0; tiaPixEn = 1'b0; tiaVsync = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("idle", i, {outLum, outHue, vgaBlank, vgaHsync, vgaVsync}, 11'b0000_0000_100);
        end
    endtask

    probe_t probes[17];

    initial begin
        int nact, nhs;
        // Replay of line k=2 (pixels 0..7 blanked), line vsync 1 after a vsync-0 line.
        probes[0]  = '{2,    4'd0,  4'd0, 1'b1, 1'b0, 1'b0};
        probes[1]  = '{3,    4'd0,  4'd0, 1'b0, 1'b0, 1'b1};
        probes[2]  = '{33,   4'd0,  4'd0, 1'b0, 1'b0, 1'b1};
        probes[3]  = '{34,   4'd8,  4'd2, 1'b0, 1'b0, 1'b1};
        probes[4]  = '{38,   4'd9,  4'd2, 1'b0, 1'b0, 1'b1};
        probes[5]  = '{641,  4'd15, 4'd2, 1'b0, 1'b0, 1'b1};
        probes[6]  = '{642,  4'd0,  4'd0, 1'b0, 1'b0, 1'b1};
        probes[7]  = '{643,  4'd0,  4'd0, 1'b1, 1'b0, 1'b1};
        probes[8]  = '{658,  4'd0,  4'd0, 1'b1, 1'b0, 1'b1};
        probes[9]  = '{659,  4'd0,  4'd0, 1'b1, 1'b1, 1'b1};
        probes[10] = '{754,  4'd0,  4'd0, 1'b1, 1'b1, 1'b1};
        probes[11] = '{755,  4'd0,  4'd0, 1'b1, 1'b0, 1'b1};
        probes[12] = '{802,  4'd0,  4'd0, 1'b1, 1'b0, 1'b1};
        probes[13] = '{803,  4'd0,  4'd0, 1'b0, 1'b0, 1'b1};
        probes[14] = '{834,  4'd8,  4'd2, 1'b0, 1'b0, 1'b1};
        probes[15] = '{1459, 4'd0,  4'd0, 1'b1, 1'b1, 1'b1};
        probes[16] = '{1599, 4'd0,  4'd0, 1'b1, 1'b0, 1'b1};

        reset_n = 1'b0; tiaPixEn = 1'b0; tiaHsync = 1'b0; tiaVsync = 1'b0;
        tiaBlank = 1'b0; tiaLum = 4'd0; tiaHue = 4'd0;
        for (int p = 0; p < 160; p++) pend_cap[p] = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset", 0, {outLum, outHue, vgaBlank, vgaHsync, vgaVsync}, 11'b0000_0000_100);
        reset_n = 1'b1;
        idle_cycles(5);

        set_line(1, 0); run_line(1600, 7, 0, 1'b0, 1'b0);   // strobe coincides with event
        set_line(2, 8); run_line(1600, 7, 3, 1'b0, 1'b0);   // HMOVE-style blank bar
        set_line(3, 0); run_line(1600, 7, 5, 1'b1, 1'b1);

        for (int i = 0; i < 17; i++)
            check("probe", probes[i].t, trace[probes[i].t],
                  {probes[i].lum, probes[i].hue, probes[i].blank, probes[i].hs, probes[i].vs});
        nact = 0; nhs = 0;
        for (int c = 0; c < 1600; c++) begin
            if (!trace[c][2]) nact++;
            if (trace[c][1]) nhs++;
        end
        check_int("active_clks", nact, 1280);
        check_int("hsync_clks", nhs, 192);

        set_line(4, 0); run_line(1201, 5, 2, 1'b0, 1'b0);   // next event at hCount=400 of LINE1
        set_line(5, 0); run_line(1600, 7, 1, 1'b1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            rand_line();
            run_line(1600, 7, int'($urandom_range(6)), 1'($urandom_range(1)), 1'b0);
        end

        // Asynchronous reset with hCount=300 in LINE0 of a valid line.
        rand_line();
        run_line(301, 7, 0, 1'b1, 1'b0);
        reset_n = 1'b0;
        #2;
        check("reset_mid", 0, {outLum, outHue, vgaBlank, vgaHsync, vgaVsync}, 11'b0000_0000_100);
        @(posedge clk); #1;
        check("reset_hold", 1, {outLum, outHue, vgaBlank, vgaHsync, vgaVsync}, 11'b0000_0000_100);
        reset_n = 1'b1;
        model_reset();
        idle_cycles(3);
        for (int i = 0; i < 3; i++) begin
            rand_line();
            run_line(1600, 7, int'($urandom_range(6)), 1'($urandom_range(1)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
